mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Three-way arbiter that shares the single-port unified memory (19-bit address, 19-bit data, FFT window at addr[18:16]=3'b111, crypto window at 3'b110) between the CPU pipeline's MEM stage, the FFT accelerator and the crypto accelerator. It issues at most one memory access per cycle and registers the read response. It gives the CPU fixed priority, with starvation escape for the accelerators. It round-robins between the two accelerators and enforces each accelerator's address window.

## Interface
- AW, 19, address width
- DW, 19, data width
- STARVE_LIMIT, 8, denied-cycle count at which a waiting accelerator overrides the CPU (1..15)

Ports. Each requester prefix r ∈ {cpu, fft, cry} has the same set of signals.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- r_req  in  1  access request; held with r_we/r_addr/r_wdata stable until r_gnt
- r_we  in  1  1 = write, 0 = read
- r_addr  in  AW  word address
- r_wdata  in  DW  write data
- r_gnt  out  1  access accepted this cycle (combinational)
- r_rvalid  out  1  read data valid (registered, 1-cycle pulse)
- r_rdata  out  DW  read data, valid with r_rvalid
- err_fft, err_cry  out  1  window-violation pulse (registered)
- mem_write, mem_read  out  1  memory strobes (combinational)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational from mem_addr when mem_read=1

## Operation
- **Winner selection.** The winner is chosen each cycle from the current requests, in this order:
  1. An accelerator whose wait counter equals STARVE_LIMIT. If both are starving, FFT wins.
  2. The CPU, if cpu_req.
  3. Between FFT and crypto, the round-robin pointer decides. The pointer points to the preferred accelerator. After an accelerator is granted, the pointer moves to the other one. Starvation grants also update the pointer.
- **Grant.** Exactly one r_gnt goes high, for the winner only. All r_gnt are forced to 0 while rst_n=0.
- **Wait counters (fft, cry).** Each is 4 bits.
  - +1 per cycle while req=1 and gnt=0; saturates at STARVE_LIMIT.
  - Cleared on grant or when req=0.
- **Memory drive.** mem_addr and mem_wdata follow the winner. When there is no winner, they hold 0. mem_write = gnt & we & window_ok. mem_read = gnt & ~we & window_ok.
- **Window check.**
  - CPU: always OK.
  - FFT: OK only if addr[18:16]=3'b111.
  - Crypto: OK only if addr[18:16]=3'b110.
  - On a violating access, the request is still granted (consumed) but no strobe is issued. err_x pulses for 1 cycle after the grant.
- **Read response.** For a granted read, rdata_reg <= (window_ok ? mem_rdata : 0). The matching r_rvalid pulses in the next cycle. Writes produce no rvalid.
- **rdata hold.** r_rdata holds its last value between pulses.
- **Shared response register.** One response register is shared by all requesters; only the winner's r_rvalid is set.
- **Back-to-back grants.** A requester may be granted on consecutive cycles.

## Timing
- **Reset values.** All r_rvalid, r_rdata, err_* = 0. Wait counters = 0. Pointer = FFT. r_gnt and memory strobes = 0 while rst_n=0.
- **Grant latency.** Grant is in the same cycle as the request if it wins.
- **Write.** Committed by memory at the rising edge that ends the grant cycle.
- **Read latency.** 1 cycle: grant in cycle N, r_rvalid/r_rdata in cycle N+1.
- **Starvation bound.** Worst case, an accelerator is granted within STARVE_LIMIT+1 cycles of raising req. Under CPU saturation, it is granted in the cycle its counter reads STARVE_LIMIT.
- **Request withdrawn before grant.** Allowed. The counter clears and nothing is issued.
- **Reset assertion mid-read.** Pending rvalid is cleared immediately (async) and no response is delivered. After rst_n deasserts, the first active edge behaves as from reset.
- **Simultaneous events.**
  - CPU and non-starving accelerator: the CPU wins.
  - Both accelerators without CPU: the pointer decides.
  - Both starving: FFT wins, then the crypto counter, still saturated, wins the next cycle over the CPU.

## Test plan
- **CPU write then read.** CPU writes 0x12345 @0x00010, then reads 0x00010. Expect cpu_gnt same cycle and mem_write for 1 cycle, then cpu_rvalid one cycle after the read grant with cpu_rdata=0x12345.
- **Accelerator round-robin.** FFT (@0x70000..) and crypto (@0x60000..) both request continuously, no CPU. Expect grants alternating fft, cry, fft, cry…, with fft first after reset.
- **Starvation override.** CPU requests every cycle; FFT raises req at cycle 0, STARVE_LIMIT=8. Expect cpu_gnt on cycles 0–7, fft_gnt on cycle 8, cpu_gnt on cycle 9, fft counter 0 afterwards.
- **Window violation.**
  - FFT write to 0x10005: expect fft_gnt with mem_write=0, err_fft=1 for exactly one cycle, memory unchanged.
  - Crypto read to 0x70000: expect cry_rvalid with cry_rdata=0 and err_cry pulse.
- **Both starving.** Both accelerators starve under CPU load. Expect fft granted at the saturation cycle, cry the next cycle, then CPU.
- **Reset mid-read.** Assert rst_n low in the cycle after a CPU read grant. Expect cpu_rvalid=0 immediately, all gnt=0 during reset, clean operation after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-way arbiter for the unified single-port memory.
// The CPU MEM stage has fixed priority. The FFT and crypto accelerators share a
// round-robin slot, and either one can override the CPU once it has waited too long.
// Each accelerator is restricted to its own address window. A violating access
// is consumed without a memory strobe and raises a one-cycle error pulse.
// All requesters share one registered read-response register.
module mem_arbiter #(
  parameter int unsigned AW           = 19,
  parameter int unsigned DW           = 19,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          fft_req,
  input  logic          fft_we,
  input  logic [AW-1:0] fft_addr,
  input  logic [DW-1:0] fft_wdata,
  output logic          fft_gnt,
  output logic          fft_rvalid,
  output logic [DW-1:0] fft_rdata,

  input  logic          cry_req,
  input  logic          cry_we,
  input  logic [AW-1:0] cry_addr,
  input  logic [DW-1:0] cry_wdata,
  output logic          cry_gnt,
  output logic          cry_rvalid,
  output logic [DW-1:0] cry_rdata,

  output logic          err_fft,
  output logic          err_cry,

  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] Limit  = 4'(STARVE_LIMIT);
  localparam logic [2:0] FftWin = 3'b111;
  localparam logic [2:0] CryWin = 3'b110;

  typedef enum logic [1:0] {SelNone, SelCpu, SelFft, SelCry} sel_e;

  sel_e          sel;
  logic [3:0]    fft_wait_q, fft_wait_d;
  logic [3:0]    cry_wait_q, cry_wait_d;
  logic          rr_cry_q, rr_cry_d;   // 1: crypto is preferred on the next tie
  logic          fft_starve, cry_starve;
  logic          fft_ok, cry_ok;
  logic          win_we, win_ok;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          fft_rvalid_q, fft_rvalid_d;
  logic          cry_rvalid_q, cry_rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_fft_q, err_fft_d;
  logic          err_cry_q, err_cry_d;

  assign fft_ok     = (fft_addr[AW-1 -: 3] == FftWin);
  assign cry_ok     = (cry_addr[AW-1 -: 3] == CryWin);
  assign fft_starve = fft_req && (fft_wait_q == Limit);
  assign cry_starve = cry_req && (cry_wait_q == Limit);

  // Winner selection: starving accelerator, then CPU, then round-robin pair.
  always_comb begin
    sel = SelNone;
    if (!rst_n) begin
      sel = SelNone;
    end else if (fft_starve) begin
      sel = SelFft;
    end else if (cry_starve) begin
      sel = SelCry;
    end else if (cpu_req) begin
      sel = SelCpu;
    end else if (fft_req && cry_req) begin
      sel = rr_cry_q ? SelCry : SelFft;
    end else if (fft_req) begin
      sel = SelFft;
    end else if (cry_req) begin
      sel = SelCry;
    end
  end

  assign cpu_gnt = (sel == SelCpu);
  assign fft_gnt = (sel == SelFft);
  assign cry_gnt = (sel == SelCry);

  // Route the winner onto the memory port; everything is zero when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    win_we    = 1'b0;
    win_ok    = 1'b0;
    unique case (sel)
      SelCpu: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        win_we    = cpu_we;
        win_ok    = 1'b1;
      end
      SelFft: begin
        mem_addr  = fft_addr;
        mem_wdata = fft_wdata;
        win_we    = fft_we;
        win_ok    = fft_ok;
      end
      SelCry: begin
        mem_addr  = cry_addr;
        mem_wdata = cry_wdata;
        win_we    = cry_we;
        win_ok    = cry_ok;
      end
      SelNone: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
    mem_write = (sel != SelNone) && win_we && win_ok;
    mem_read  = (sel != SelNone) && !win_we && win_ok;
  end

  // Wait counters and round-robin pointer next state.
  always_comb begin
    fft_wait_d = '0;
    cry_wait_d = '0;
    rr_cry_d   = rr_cry_q;
    if (fft_req && !fft_gnt) begin
      fft_wait_d = (fft_wait_q >= Limit) ? Limit : fft_wait_q + 4'd1;
    end
    if (cry_req && !cry_gnt) begin
      cry_wait_d = (cry_wait_q >= Limit) ? Limit : cry_wait_q + 4'd1;
    end
    // Starvation grants move the pointer too, so the other side gets the next tie.
    if (fft_gnt) begin
      rr_cry_d = 1'b1;
    end else if (cry_gnt) begin
      rr_cry_d = 1'b0;
    end
  end

  // Read response and error pulse next state.
  always_comb begin
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    fft_rvalid_d = fft_gnt && !fft_we;
    cry_rvalid_d = cry_gnt && !cry_we;
    err_fft_d    = fft_gnt && !fft_ok;
    err_cry_d    = cry_gnt && !cry_ok;
    rdata_d      = rdata_q;
    // A read that violates its window still completes, returning zero.
    if ((sel != SelNone) && !win_we) begin
      rdata_d = win_ok ? mem_rdata : '0;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fft_wait_q <= '0;
      cry_wait_q <= '0;
      rr_cry_q   <= 1'b0;
    end else begin
      fft_wait_q <= fft_wait_d;
      cry_wait_q <= cry_wait_d;
      rr_cry_q   <= rr_cry_d;
    end
  end

  // Response and error registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid_q <= 1'b0;
      fft_rvalid_q <= 1'b0;
      cry_rvalid_q <= 1'b0;
      rdata_q      <= '0;
      err_fft_q    <= 1'b0;
      err_cry_q    <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      fft_rvalid_q <= fft_rvalid_d;
      cry_rvalid_q <= cry_rvalid_d;
      rdata_q      <= rdata_d;
      err_fft_q    <= err_fft_d;
      err_cry_q    <= err_cry_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign fft_rvalid = fft_rvalid_q;
  assign cry_rvalid = cry_rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign fft_rdata  = rdata_q;
  assign cry_rdata  = rdata_q;
  assign err_fft    = err_fft_q;
  assign err_cry    = err_cry_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({cpu_gnt, fft_gnt, cry_gnt}));
  a_wait_bound : assert property (@(posedge clk) disable iff (!rst_n)
    (fft_wait_q <= Limit) && (cry_wait_q <= Limit));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW    = 19;
  localparam int DW    = 19;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req, cpu_we, fft_req, fft_we, cry_req, cry_we;
  logic [AW-1:0] cpu_addr, fft_addr, cry_addr;
  logic [DW-1:0] cpu_wdata, fft_wdata, cry_wdata;
  logic          cpu_gnt, fft_gnt, cry_gnt;
  logic          cpu_rvalid, fft_rvalid, cry_rvalid;
  logic [DW-1:0] cpu_rdata, fft_rdata, cry_rdata;
  logic          err_fft, err_cry, mem_write, mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] dev_mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  // Model state
  logic [DW-1:0] mmem [int];
  int            w_fft, w_cry, m_win;   // m_win: 0 none, 1 cpu, 2 fft, 3 cry
  bit            ptr_cry;
  logic          e_rv_cpu, e_rv_fft, e_rv_cry, e_err_fft, e_err_cry;
  logic [DW-1:0] e_rdata;

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? dev_mem[mem_addr] : '0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fft_req(fft_req), .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
    .fft_gnt(fft_gnt), .fft_rvalid(fft_rvalid), .fft_rdata(fft_rdata),
    .cry_req(cry_req), .cry_we(cry_we), .cry_addr(cry_addr), .cry_wdata(cry_wdata),
    .cry_gnt(cry_gnt), .cry_rvalid(cry_rvalid), .cry_rdata(cry_rdata),
    .err_fft(err_fft), .err_cry(err_cry),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : '0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v + 1 > LIMIT) ? LIMIT : v + 1;
  endfunction

  task automatic model_reset();
    w_fft = 0; w_cry = 0; ptr_cry = 0; m_win = 0;
    e_rv_cpu = 0; e_rv_fft = 0; e_rv_cry = 0; e_err_fft = 0; e_err_cry = 0;
    e_rdata = '0;
  endtask

  // Check one cycle at the falling edge, then advance the model by one cycle.
  task automatic sample();
    logic          w_we, ok;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_gnt", {29'd0, cpu_gnt, fft_gnt, cry_gnt}, 0);
      chk("rst_strobe", {30'd0, mem_write, mem_read}, 0);
      chk("rst_rvalid", {29'd0, cpu_rvalid, fft_rvalid, cry_rvalid}, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_err", {30'd0, err_fft, err_cry}, 0);
      model_reset();
    end else begin
      chk("cpu_rvalid", cpu_rvalid, e_rv_cpu);
      chk("fft_rvalid", fft_rvalid, e_rv_fft);
      chk("cry_rvalid", cry_rvalid, e_rv_cry);
      chk("cpu_rdata", cpu_rdata, e_rdata);
      chk("fft_rdata", fft_rdata, e_rdata);
      chk("cry_rdata", cry_rdata, e_rdata);
      chk("err_fft", err_fft, e_err_fft);
      chk("err_cry", err_cry, e_err_cry);
      if (fft_req && w_fft == LIMIT)      m_win = 2;
      else if (cry_req && w_cry == LIMIT) m_win = 3;
      else if (cpu_req)                   m_win = 1;
      else if (fft_req && cry_req)        m_win = ptr_cry ? 3 : 2;
      else if (fft_req)                   m_win = 2;
      else if (cry_req)                   m_win = 3;
      else                                m_win = 0;
      w_we = 0; ok = 0; w_addr = '0; w_wdata = '0;
      case (m_win)
        1: begin w_we = cpu_we; w_addr = cpu_addr; w_wdata = cpu_wdata; ok = 1; end
        2: begin w_we = fft_we; w_addr = fft_addr; w_wdata = fft_wdata;
                 ok = (fft_addr[18:16] == 3'b111); end
        3: begin w_we = cry_we; w_addr = cry_addr; w_wdata = cry_wdata;
                 ok = (cry_addr[18:16] == 3'b110); end
        default: ;
      endcase
      chk("cpu_gnt", cpu_gnt, m_win == 1);
      chk("fft_gnt", fft_gnt, m_win == 2);
      chk("cry_gnt", cry_gnt, m_win == 3);
      chk("mem_write", mem_write, m_win != 0 && w_we && ok);
      chk("mem_read", mem_read, m_win != 0 && !w_we && ok);
      chk("mem_addr", mem_addr, w_addr);
      chk("mem_wdata", mem_wdata, w_wdata);
      // Device memory commit (one access per cycle, so timing within the cycle is moot).
      if (mem_write) dev_mem[mem_addr] = mem_wdata;
      e_rv_cpu = (m_win == 1) && !w_we;
      e_rv_fft = (m_win == 2) && !w_we;
      e_rv_cry = (m_win == 3) && !w_we;
      if (m_win != 0 && !w_we) e_rdata = ok ? mread(w_addr) : '0;
      if (m_win != 0 && w_we && ok) mmem[int'(w_addr)] = w_wdata;
      e_err_fft = (m_win == 2) && !ok;
      e_err_cry = (m_win == 3) && !ok;
      w_fft = (fft_req && m_win != 2) ? sat_inc(w_fft) : 0;
      w_cry = (cry_req && m_win != 3) ? sat_inc(w_cry) : 0;
      if (m_win == 2) ptr_cry = 1;
      else if (m_win == 3) ptr_cry = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    fft_req = 0; fft_we = 0; fft_addr = '0; fft_wdata = '0;
    cry_req = 0; cry_we = 0; cry_addr = '0; cry_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    sample();
    adv();
    rst_n = 1;
  endtask

  function automatic logic [AW-1:0] rnd_addr(input logic [2:0] top);
    return {top, 12'h000, 4'($urandom)};
  endfunction

  function automatic logic [2:0] acc_top(input logic [2:0] win);
    return ($urandom_range(0, 7) == 0) ? 3'($urandom) : win;
  endfunction

  // Requests stay stable until granted; accelerators occasionally withdraw.
  task automatic rand_drive(input int cpu_pct, input int acc_pct);
    logic [2:0] ctop;
    if (!cpu_req || m_win == 1) begin
      cpu_req = ($urandom_range(0, 99) < cpu_pct);
      cpu_we  = 1'($urandom);
      case ($urandom_range(0, 2))
        0:       ctop = 3'b000;
        1:       ctop = 3'b110;
        default: ctop = 3'b111;
      endcase
      cpu_addr  = rnd_addr(ctop);
      cpu_wdata = DW'($urandom);
    end
    if (!fft_req || m_win == 2) begin
      fft_req   = ($urandom_range(0, 99) < acc_pct);
      fft_we    = 1'($urandom);
      fft_addr  = rnd_addr(acc_top(3'b111));
      fft_wdata = DW'($urandom);
    end else if ($urandom_range(0, 31) == 0) begin
      fft_req = 0;
    end
    if (!cry_req || m_win == 3) begin
      cry_req   = ($urandom_range(0, 99) < acc_pct);
      cry_we    = 1'($urandom);
      cry_addr  = rnd_addr(acc_top(3'b110));
      cry_wdata = DW'($urandom);
    end else if ($urandom_range(0, 31) == 0) begin
      cry_req = 0;
    end
  endtask

  initial begin
    foreach (dev_mem[i]) dev_mem[i] = '0;
    model_reset();
    idle();
    rst_n = 0;
    repeat (2) begin sample(); adv(); end
    rst_n = 1;

    // Reset state out of reset
    sample();
    chk("init_rvalid", {29'd0, cpu_rvalid, fft_rvalid, cry_rvalid}, 0);
    chk("init_rdata", cpu_rdata, 0);
    chk("init_gnt", {29'd0, cpu_gnt, fft_gnt, cry_gnt}, 0);
    adv();

    // CPU write then read
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00010; cpu_wdata = 19'h12345;
    sample();
    chk("t_wr_gnt", cpu_gnt, 1);
    chk("t_wr_strobe", mem_write, 1);
    adv();
    cpu_we = 0;
    sample();
    chk("t_rd_gnt", cpu_gnt, 1);
    chk("t_rd_nowrite", mem_write, 0);
    adv();
    idle();
    sample();
    chk("t_rd_rvalid", cpu_rvalid, 1);
    chk("t_rd_rdata", cpu_rdata, 19'h12345);
    adv();

    // Accelerator round-robin from reset
    do_reset();
    fft_req = 1; fft_addr = 19'h70000;
    cry_req = 1; cry_addr = 19'h60000;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("rr_fft", fft_gnt, (i % 2) == 0);
      chk("rr_cry", cry_gnt, (i % 2) == 1);
      adv();
    end
    idle();
    sample(); adv();

    // Starvation override under CPU saturation
    cpu_req = 1; cpu_addr = 19'h00020;
    fft_req = 1; fft_we = 1; fft_addr = 19'h70001; fft_wdata = 19'h2AAAA;
    for (int c = 0; c < 10; c++) begin
      sample();
      chk("stv_fft", fft_gnt, c == 8);
      chk("stv_cpu", cpu_gnt, c != 8);
      if (c == 9) chk("stv_cnt", dut.fft_wait_q, 0);
      adv();
      if (c == 8) fft_req = 0;
    end
    idle();
    sample(); adv();

    // Window violations
    fft_req = 1; fft_we = 1; fft_addr = 19'h10005; fft_wdata = 19'h55555;
    sample();
    chk("win_fft_gnt", fft_gnt, 1);
    chk("win_fft_nowr", mem_write, 0);
    adv();
    idle();
    sample();
    chk("win_err_fft", err_fft, 1);
    adv();
    sample();
    chk("win_err_fft_end", err_fft, 0);
    chk("win_mem_kept", dev_mem[19'h10005], 0);
    adv();
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h70000; cpu_wdata = 19'h4ABCD;
    sample(); adv();
    idle();
    cry_req = 1; cry_we = 0; cry_addr = 19'h70000;
    sample();
    chk("win_cry_gnt", cry_gnt, 1);
    chk("win_cry_nord", mem_read, 0);
    adv();
    idle();
    sample();
    chk("win_cry_rvalid", cry_rvalid, 1);
    chk("win_cry_rdata", cry_rdata, 0);
    chk("win_err_cry", err_cry, 1);
    adv();

    // Both accelerators starving
    cpu_req = 1; cpu_addr = 19'h00020;
    fft_req = 1; fft_we = 1; fft_addr = 19'h70002; fft_wdata = 19'h11111;
    cry_req = 1; cry_we = 0; cry_addr = 19'h60003;
    for (int c = 0; c < 11; c++) begin
      sample();
      chk("bs_cpu", cpu_gnt, (c < 8) || (c == 10));
      chk("bs_fft", fft_gnt, c == 8);
      chk("bs_cry", cry_gnt, c == 9);
      adv();
      if (c == 8) fft_req = 0;
      if (c == 9) cry_req = 0;
    end
    idle();
    sample(); adv();

    // Reset asserted right after a read grant
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00010;
    sample();
    chk("mr_gnt", cpu_gnt, 1);
    adv();
    rst_n = 0;
    #1;
    chk("mr_rvalid_drop", cpu_rvalid, 0);
    sample();
    chk("mr_gnt_rst", cpu_gnt, 0);
    adv();
    sample(); adv();
    rst_n = 1;
    sample();
    chk("mr_gnt_after", cpu_gnt, 1);
    adv();
    sample();
    chk("mr_rvalid_after", cpu_rvalid, 1);
    chk("mr_rdata_after", cpu_rdata, 19'h12345);
    adv();
    idle();

    // Randomized traffic: moderate then saturating CPU load
    for (int i = 0; i < 5000; i++) begin
      sample();
      adv();
      if (i == 1200) rst_n = 0;
      else rst_n = 1;
      rand_drive((i < 2500) ? 50 : 95, (i < 2500) ? 60 : 80);
    end
    idle();
    sample(); adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
